// File: rtl/parity_pkg.sv
// Shared constants for the parity deserialiser and the odd_sel checker.
// State encoding and parity-mode values live here so both blocks agree.
package parity_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_PAR  = 2'd2;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_DATA = ST_DATA,
        S_PAR  = ST_PAR
    } state_t;

endpackage

// File: rtl/parity_deser_if.sv
// Serial-in / parallel-out bundle of the parity deserialiser.
// master drives the serial side, slave is the deserialiser itself.
interface parity_deser_if #(
    parameter int WIDTH = 32
);
    logic             sel;
    logic             din;
    logic             din_valid;
    logic [WIDTH-1:0] bus;
    logic             bus_valid;
    logic             check;
    logic             busy;

    modport master (
        output sel, din, din_valid,
        input  bus, bus_valid, check, busy
    );

    modport slave (
        input  sel, din, din_valid,
        output bus, bus_valid, check, busy
    );
endinterface

// File: rtl/parity_deser_acc.sv
// Running XOR of the data bits of one frame.
// Clear has priority over enable so a start bit always begins from zero.
module parity_acc (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_bit,
    output logic o_acc
);
    logic r_acc;

    // accumulate one bit per enabled cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= 1'b0;
        end else if (i_clr) begin
            r_acc <= 1'b0;
        end else if (i_en) begin
            r_acc <= r_acc ^ i_bit;
        end
    end

    assign o_acc = r_acc;
endmodule

// File: rtl/parity_deser.sv
// Framed serial receiver: start bit, WIDTH data bits LSB first, parity.
// Optional macro PARITY_DESER_ERRCNT_EN adds a saturating err_cnt output.
module parity_deser
    import parity_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
`ifdef PARITY_DESER_ERRCNT_EN
    parity_deser_if.slave bus_if,
    output logic [7:0]   err_cnt
`else
    parity_deser_if.slave bus_if
`endif
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sel;
    logic [WIDTH-1:0] r_bus;
    logic             r_valid;
    logic             r_check;
    logic             r_busy;

    logic w_start;
    logic w_take;
    logic w_acc;
    logic w_tot;

    assign w_start = (r_state == S_IDLE) && bus_if.din_valid
                     && !bus_if.din;
    assign w_take  = (r_state == S_DATA) && bus_if.din_valid;
    assign w_tot   = w_acc ^ bus_if.din;

    parity_acc u_acc (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_start),
        .i_en  (w_take),
        .i_bit (bus_if.din),
        .o_acc (w_acc)
    );

    // frame FSM: collect bits, then publish word and check flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_sel   <= PAR_EVEN;
            r_bus   <= '0;
            r_valid <= 1'b0;
            r_check <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_DATA;
                        r_busy  <= 1'b1;
                        r_sel   <= bus_if.sel;
                        r_shift <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_DATA: begin
                    if (bus_if.din_valid) begin
                        // shift in from the top: first bit ends at LSB
                        r_shift <= {bus_if.din, r_shift[WIDTH-1:1]};
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt == LAST) begin
                            r_state <= S_PAR;
                        end
                    end
                end
                S_PAR: begin
                    if (bus_if.din_valid) begin
                        r_bus   <= r_shift;
                        r_valid <= 1'b1;
                        r_check <= (r_sel == PAR_ODD) ? w_tot : ~w_tot;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_if.bus       = r_bus;
    assign bus_if.bus_valid = r_valid;
    assign bus_if.check     = r_check;
    assign bus_if.busy      = r_busy;

`ifdef PARITY_DESER_ERRCNT_EN
    logic [7:0] r_err;

    // count published words whose parity disagreed, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 8'd0;
        end else if (r_valid && !r_check && (r_err != 8'hFF)) begin
            r_err <= r_err + 8'd1;
        end
    end

    assign err_cnt = r_err;
`endif
endmodule

// File: doc/parity_deser.md
Name: parity_deser

Overview:
- Serial-to-parallel front end that feeds the parity checker (odd_sel) its 32-bit bus.
- Receives a framed serial stream: start bit, WIDTH data bits LSB first, one parity bit.
- Assembles the word and tracks parity incrementally.
- Presents the word with a one-cycle valid pulse and a check flag computed under the odd/even select.

Parameters:
- WIDTH, 32, data bits per frame; legal range 2..64.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- sel  in  1  parity mode: 1 = odd, 0 = even. Sampled at the start bit.
- din  in  1  serial data bit.
- din_valid  in  1  din is meaningful this cycle; low = stall, no bit consumed.
- bus  out  WIDTH  last completed word; held until the next frame completes.
- bus_valid  out  1  one-cycle pulse when bus/check update.
- check  out  1  1 = received parity bit consistent with the mode latched for that frame.
- busy  out  1  high from the accepted start bit until the frame completes.

Behaviour:
- Reset (async assert, sync release): state IDLE, bus=0, bus_valid=0, check=0, busy=0, counter=0, parity accumulator=0, latched sel=0.
- FSM states: IDLE, DATA, PAR.
  - IDLE: din_valid=1 and din=0 is the start bit. Go to DATA, busy=1, latch sel, clear shift register, counter and accumulator. din_valid=1 with din=1 is idle line; ignore it.
  - DATA: each din_valid=1 cycle shifts din into bit position counter (LSB first), XORs din into the accumulator and increments the counter. After WIDTH accepted bits, go to PAR.
  - PAR: on din_valid=1, take the received parity bit p.
    - Total ones = acc ^ p.
    - check = latched_sel ? (acc^p) : ~(acc^p).
    - Load bus from the shift register, pulse bus_valid for exactly one cycle, busy=0, return to IDLE.
- Latency: bus/bus_valid/check register on the clock edge that accepts the parity bit; visible the following cycle.
- Stalls: din_valid=0 in any state holds all state; no timeout.
- sel changes mid-frame have no effect; the new value applies from the next start bit.
- Back-to-back frames: a start bit may arrive the cycle after the parity bit. bus_valid of the old frame and acceptance of the new start bit may overlap without interference.
- Reset mid-frame: partial word discarded, bus returns to 0, no bus_valid pulse.
- Counter never exceeds WIDTH; no wrap-around.

Optional Feature:
- Macro PARITY_DESER_ERRCNT_EN.
- When defined:
  - Adds output err_cnt [7:0].
  - Increments on each bus_valid pulse with check=0.
  - Saturates at 255; reset to 0.
- When undefined: port absent, no counter logic.

Decomposition:
- Shared package parity_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_DATA=2'd1, ST_PAR=2'd2.
  - parity mode constants PAR_EVEN=1'b0, PAR_ODD=1'b1; reused by odd_sel.
- Optional sub-module parity_acc: 1-bit XOR accumulator with clear/enable. Small enough to inline; keep separate only for reuse.

Test Plan:
1. rst pulse mid-idle, then sel=0; frame of start, 32'h0000_0003, p=0 -> after parity bit: bus_valid pulse, bus=32'h0000_0003, check=1. Then p=1 for the same word -> check=0.
2. sel=1 (odd); frame 32'h0000_0001 with p=0 -> check=1. Then 32'hFFFF_FFFF with p=1 -> check=1. Toggle sel mid-frame -> result unaffected.
3. Stalls:
   - Insert 3-cycle din_valid=0 gaps after bits 0, 15 and 31 of 32'hA5A5_5A5A, sel=0, p=0 -> bus=32'hA5A5_5A5A, check=1.
   - Bus unchanged and busy=1 throughout the gaps.
4. Back-to-back: 32'h0000_0001 then 32'h8000_0000, start bit on the cycle after the first parity bit -> two bus_valid pulses one frame apart, both words correct.
5. Assert rst after 10 data bits -> bus=0, busy=0, no bus_valid. Next full frame 32'h1234_5678 (sel=0, p=1) -> check=1.
6. With PARITY_DESER_ERRCNT_EN: 300 frames with wrong parity -> err_cnt saturates at 255. Then rst -> err_cnt=0.
